// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the PC through instruction memory, issues words
// to decode, handles stall/branch redirects and stops on a halt word.
module instr_fetch #(
  parameter int unsigned        PC_W      = 8,
  parameter int unsigned        INSTR_W   = 9,
  parameter logic [INSTR_W-1:0] HALT_CODE = INSTR_W'(9'h0FF),
  parameter int unsigned        CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_en,
  input  logic               branch_rel,
  input  logic [PC_W-1:0]    target,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    instr_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               done,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             issue;
  logic             is_halt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next state, next PC and issue decision
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    issue   = 1'b0;
    is_halt = (instr_in == HALT_CODE);
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        // A stalled cycle freezes everything, including halt detection
        if (!stall) begin
          if (is_halt) begin
            state_d = S_HALT;
            done_d  = 1'b1;
          end else begin
            issue = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            // Relative add wraps modulo 2^PC_W, matching a sign-extended offset
            if (branch_en) pc_d = branch_rel ? (pc_q + target) : target;
            else           pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign instr       = (state_q == S_RUN) ? instr_in : '0;
  assign instr_valid = issue;
  assign instr_addr  = pc_q;
  assign pc          = pc_q;
  assign done        = done_q;
  assign instr_count = cnt_q;

endmodule
